// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory: funct3 codes, lane masks, legality checks.
// Pure declarations; no state, no latency, no flow control.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] dat;
  } rsp_stage_t;

  // Access size is encoded in funct3[1:0] for every legal code.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    case (funct3[1:0])
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic access_ok(input logic we, input logic [2:0] funct3, input logic [1:0] off);
    logic legal;
    logic aligned;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !we;
      default:          legal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !off[0];
      default: aligned = (off == 2'b00);
    endcase
    return legal && aligned;
  endfunction

  function automatic logic [31:0] store_rep(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] d;
    case (funct3[1:0])
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bundle between a load/store unit (master) and the data memory (slave).
// No backpressure on responses; req_ready gates acceptance only.
interface dmem_bytelane_if #(
  parameter int ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_load_ext.sv
// Selects the addressed lane of a 32-bit word and sign/zero-extends it per funct3.
// Purely combinational; illegal funct3 yields zero.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_word >> {i_off, 3'b000};

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_data = w_shifted;
      F3_BU:   o_data = {24'h0, w_shifted[7:0]};
      F3_HU:   o_data = {16'h0, w_shifted[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed RV32 data memory: lane-masked stores commit at acceptance, loads return after READ_LAT cycles.
// One request per cycle; req_ready is high whenever out of reset, responses are never stalled.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1,
  parameter int ADDR_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  dmem_bytelane_if.slave  bus
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) * 64'd4;

  logic        r_ready;
  logic [31:0] r_mem [DEPTH_WORDS];
  rsp_stage_t  r_pipe [READ_LAT];

  logic             w_accept;
  logic             w_oor;
  logic             w_err;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic [3:0]       w_mask;
  logic [31:0]      w_wdata_rep;
  logic [31:0]      w_rd_word;
  logic [31:0]      w_ld_data;
  rsp_stage_t       w_stage0;

  assign w_accept    = bus.req_valid && r_ready;
  assign w_idx       = bus.req_addr[IDX_W+1:2];
  assign w_off       = bus.req_addr[1:0];
  assign w_oor       = (64'(bus.req_addr) >= BYTE_LIMIT);
  assign w_err       = w_oor || !access_ok(bus.req_we, bus.req_funct3, w_off);
  assign w_wr_en     = w_accept && bus.req_we && !w_err;
  assign w_mask      = lane_mask(bus.req_funct3, w_off);
  assign w_wdata_rep = store_rep(bus.req_funct3, bus.req_wdata);
  assign w_rd_word   = r_mem[w_idx];

  dmem_load_ext u_load_ext (
    .i_word   (w_rd_word),
    .i_off    (w_off),
    .i_funct3 (bus.req_funct3),
    .o_data   (w_ld_data)
  );

  // Array has no reset: contents must survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_stage0     = '0;
    w_stage0.vld = w_accept;
    w_stage0.err = w_accept && w_err;
    if (w_accept && !bus.req_we && !w_err) begin
      w_stage0.dat = w_ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
      for (int k = 0; k < READ_LAT; k++) begin
        r_pipe[k] <= '0;
      end
    end else begin
      r_ready   <= 1'b1;
      r_pipe[0] <= w_stage0;
      for (int k = 1; k < READ_LAT; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_pipe[READ_LAT-1].vld;
  assign bus.rsp_err   = r_pipe[READ_LAT-1].err;
  assign bus.rsp_rdata = r_pipe[READ_LAT-1].dat;

endmodule
